mem_sp_param: RTL and testbench
===============================

Name: mem_sp_param

Overview:
Parametrised single-port RAM. It generalises the team's fixed 32Kx16 memory to configurable address and data widths, and adds per-lane write enables, a selectable async or registered read port, and a hardware zero-fill sequencer. The zero-fill runs after reset and whenever requested. It sits in the same place as the fixed memory, feeding the datapath load/store unit, and is inferred RAM rather than vendor IP.

Parameters:
AW, 15, address width; depth is 2**AW words.
DW, 16, data word width; must be a multiple of BW.
BW, 8, byte-lane width; NB = DW/BW lanes.
REG_OUT, 0, 0 = combinational read (spo follows a); 1 = registered read (1-cycle latency).
INIT_CLEAR, 1, 1 = zero-fill all words automatically after reset deasserts.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
a  input  AW  word address for read and write.
d  input  DW  write data.
we  input  1  write enable.
be  input  NB  lane enables; lane i covers d[i*BW +: BW].
clr  input  1  single-cycle request to zero-fill the whole array.
spo  output  DW  read data.
busy  output  1  high while the zero-fill sequencer owns the array.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to CLEAR if INIT_CLEAR=1, else IDLE.
  - Clear counter resets to 0.
  - busy resets to INIT_CLEAR.
  - spo register (REG_OUT=1) resets to 0.
  - Array contents are not reset by rst.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr=1 at a rising edge; counter loads 0.
  - CLEAR: each cycle writes all-zero to mem[cnt], then cnt increments.
  - CLEAR -> IDLE on the edge that writes address 2**AW-1; busy falls in the same edge.
  - A full clear is exactly 2**AW cycles with busy=1.
- busy = (state==CLEAR), registered.
- While busy=1:
  - we, be, d and clr are ignored.
  - spo is forced to 0: combinationally for REG_OUT=0, by loading 0 into the output register for REG_OUT=1.
- User write in IDLE: at a rising edge with we=1, mem[a][lane i] <= d[lane i] for every i with be[i]=1. Other lanes are unchanged. be=0 with we=1 is a no-op.
- clr and we in the same IDLE cycle: clr wins, the write is discarded, and the clear starts.
- rst asserted mid-clear: counter returns to 0. If INIT_CLEAR=1 the clear restarts from address 0 after release; otherwise the FSM returns to IDLE with the array partially cleared.
- Read, REG_OUT=0:
  - spo = mem[a] combinationally.
  - A write at edge t is visible on spo immediately after edge t when a is unchanged.
- Read, REG_OUT=1:
  - spo <= mem[a] at each rising edge.
  - Read-first: a read and write to the same address at the same edge return the old data; the new data appears one cycle later.
- Address is unsigned and in range by construction; no wrap logic is needed beyond the counter's natural AW-bit width.
- No outputs other than spo and busy.

Test Plan:
- AW=4, INIT_CLEAR=1: release rst -> busy=1 for exactly 16 cycles then 0. Afterwards every address 0..15 reads 0x0000.
- IDLE, REG_OUT=0: write a=3, d=0xBEEF, be=2'b11; then be=2'b01, d=0x1234 to a=3 -> spo at a=3 reads 0xBEEF, then 0xBE34.
- REG_OUT=1: same-edge read/write at a=5 (old 0x0000, new 0xA5A5) -> spo=0x0000 after that edge, 0xA5A5 after the next edge.
- IDLE: pulse clr together with we=1, a=7, d=0xFFFF -> write dropped, busy=1 for 16 cycles, mem[7]=0x0000. we pulses during busy leave memory zeroed.
- Assert rst at clear cycle 9 with INIT_CLEAR=1 -> busy stays 1, clear restarts at address 0, and completes 16 cycles after rst release.
- DW=32, BW=8: write 0x11223344 with be=4'b1010 over 0x00000000 -> reads 0x11003300.

Source files
------------

// File: rtl/mem_sp_param.sv
// Parametrised single-port RAM: byte-lane writes, optional registered read,
// and a zero-fill sequencer that runs after reset and on a clr request.

// One byte lane of the array: single address shared by read and write.
module mem_sp_lane #(
  parameter int AW = 15,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [BW-1:0] wd,
  output logic [BW-1:0] rd
);
  logic [BW-1:0] mem [2**AW];

  // Array contents are deliberately not reset; only the sequencer clears them.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wd;

  assign rd = mem[addr];
endmodule

module mem_sp_param #(
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int BW         = 8,
  parameter int REG_OUT    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    a,
  input  logic [DW-1:0]    d,
  input  logic             we,
  input  logic [DW/BW-1:0] be,
  input  logic             clr,
  output logic [DW-1:0]    spo,
  output logic             busy
);
  localparam int NB = DW / BW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  logic [AW-1:0]          cnt;
  logic                   busy_q;
  logic [AW-1:0]          addr;
  logic [NB-1:0]          lane_we;
  logic [NB-1:0][BW-1:0]  wdat;
  logic [NB-1:0][BW-1:0]  rdat;
  logic [DW-1:0]          rd_word;

  // Sequencer: CLEAR walks cnt over every address, leaving on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      cnt    <= '0;
      busy_q <= (INIT_CLEAR != 0);
    end else begin
      case (state)
        IDLE: if (clr) begin
          state  <= CLEAR;
          cnt    <= '0;
          busy_q <= 1'b1;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {AW{1'b1}}) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;

  // The sequencer owns the port while busy; otherwise the user address drives it.
  assign addr = busy_q ? cnt : a;

  genvar i;
  generate
    for (i = 0; i < NB; i++) begin : g_lane
      // clr beats a same-cycle write; user inputs are ignored while clearing.
      assign lane_we[i] = busy_q | (we & ~clr & be[i]);
      assign wdat[i]    = busy_q ? '0 : d[i*BW +: BW];

      mem_sp_lane #(.AW(AW), .BW(BW)) u_lane (
        .clk  (clk),
        .we   (lane_we[i]),
        .addr (addr),
        .wd   (wdat[i]),
        .rd   (rdat[i])
      );
    end
  endgenerate

  assign rd_word = rdat;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [DW-1:0] spo_q;
      // Read-first: samples the pre-write contents at the write edge.
      always_ff @(posedge clk or posedge rst)
        if (rst) spo_q <= '0;
        else     spo_q <= busy_q ? '0 : rd_word;
      assign spo = spo_q;
    end else begin : g_comb
      assign spo = busy_q ? '0 : rd_word;
    end
  endgenerate
endmodule

// File: tb/tb_mem_sp_param.sv
module tb_mem_sp_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a;
  logic        we, clr;
  logic [15:0] d;
  logic [1:0]  be;
  logic [31:0] d2;
  logic [3:0]  be2;
  logic [15:0] spo0, spo1;
  logic [31:0] spo2;
  logic        busy0, busy1, busy2;

  int ntests = 0;
  int nfail  = 0;
  int n;

  always #5 clk = ~clk;

  // Combinational read, auto clear.
  mem_sp_param #(.AW(4), .DW(16), .BW(8), .REG_OUT(0), .INIT_CLEAR(1)) u0 (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .be(be), .clr(clr),
    .spo(spo0), .busy(busy0));
  // Registered read, auto clear.
  mem_sp_param #(.AW(4), .DW(16), .BW(8), .REG_OUT(1), .INIT_CLEAR(1)) u1 (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .be(be), .clr(clr),
    .spo(spo1), .busy(busy1));
  // 32-bit word, four lanes, no clear after reset.
  mem_sp_param #(.AW(4), .DW(32), .BW(8), .REG_OUT(0), .INIT_CLEAR(0)) u2 (
    .clk(clk), .rst(rst), .a(a), .d(d2), .we(we), .be(be2), .clr(clr),
    .spo(spo2), .busy(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a = '0; we = 1'b0; clr = 1'b0; d = '0; be = '0; d2 = '0; be2 = '0;
    tick(); tick();
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_busy2", busy2, 0);
    chk("rst_spo1", spo1, 0);
    chk("rst_spo0_forced", spo0, 0);

    // Power-up clear: exactly 16 busy cycles.
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin tick(); n++; end
    chk("init_clear_len", n, 16);
    chk("init_busy1_done", busy1, 0);
    for (int i = 0; i < 16; i++) begin
      a = i[3:0];
      #1;
      chk($sformatf("init_zero_%0d", i), spo0, 0);
    end

    // Full write, then low-lane-only write.
    a = 4'd3; d = 16'hBEEF; be = 2'b11; we = 1'b1;
    tick(); we = 1'b0;
    chk("wr_full", spo0, 16'hBEEF);
    d = 16'h1234; be = 2'b01; we = 1'b1;
    tick(); we = 1'b0;
    chk("wr_lane0", spo0, 16'hBE34);
    chk("reg_readfirst_a3", spo1, 16'hBEEF);
    tick();
    chk("reg_new_a3", spo1, 16'hBE34);
    d = 16'h0000; be = 2'b00; we = 1'b1;
    tick(); we = 1'b0;
    chk("be0_noop", spo0, 16'hBE34);

    // Registered read-first at a=5.
    a = 4'd5; d = 16'hA5A5; be = 2'b11; we = 1'b1;
    tick(); we = 1'b0;
    chk("reg_old_a5", spo1, 16'h0000);
    tick();
    chk("reg_new_a5", spo1, 16'hA5A5);
    chk("comb_a5", spo0, 16'hA5A5);

    // clr with a same-cycle write: write dropped, clear starts.
    a = 4'd7; d = 16'hFFFF; be = 2'b11; we = 1'b1; clr = 1'b1;
    tick(); clr = 1'b0;
    chk("clr_busy0", busy0, 1);
    chk("clr_busy2", busy2, 1);
    chk("clr_spo0_forced", spo0, 0);
    n = 0;
    while (busy0 && n < 40) begin tick(); n++; end
    we = 1'b0;
    chk("clr_len", n, 16);
    #1;
    chk("clr_a7", spo0, 0);
    a = 4'd3; #1;
    chk("clr_a3", spo0, 0);
    a = 4'd5; #1;
    chk("clr_a5", spo0, 0);
    a = 4'd7; tick();
    chk("clr_a7_reg", spo1, 0);

    // 32-bit lane-masked writes.
    be = 2'b00;
    a = 4'd2; d2 = 32'h11223344; be2 = 4'b1010; we = 1'b1;
    tick(); we = 1'b0;
    chk("w32_mask", spo2, 32'h11003300);
    a = 4'd12; d2 = 32'hDEADBEEF; be2 = 4'b1111; we = 1'b1;
    tick(); we = 1'b0;
    chk("w32_full", spo2, 32'hDEADBEEF);

    // Reset in the middle of a clear.
    clr = 1'b1;
    tick(); clr = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy0_pre", busy0, 1);
    rst = 1'b1; #1;
    chk("mid_rst_busy0", busy0, 1);
    chk("mid_rst_busy2", busy2, 0);
    chk("mid_rst_spo1", spo1, 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin tick(); n++; end
    chk("mid_restart_len", n, 16);
    chk("mid_busy1_done", busy1, 0);
    a = 4'd12; #1;
    chk("partial_a12_kept", spo2, 32'hDEADBEEF);
    a = 4'd2; #1;
    chk("partial_a2_zero", spo2, 0);
    a = 4'd0; #1;
    chk("restart_a0", spo0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
